// File: rtl/seg_scan_ctrl.sv
// Signed 16-bit to 4-digit BCD converter (saturating at 9999) with a
// multiplexed 7-segment digit scanner that only ever shows committed results.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_inH,
  input  logic [7:0] data_inL,
  output logic       busy,
  output logic       done,
  output logic [3:0] num_C3,
  output logic [3:0] num_C2,
  output logic [3:0] num_C1,
  output logic [3:0] num_C0,
  output logic       sign,
  output logic       ovf,
  output logic [3:0] digit_sel,
  output logic [3:0] digit_val,
  output logic       digit_blank
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept, commit;
  logic [15:0] value;
  logic [16:0] abs_value;
  logic        sat;
  logic [15:0] mag_init;
  logic [15:0] mag, bcd, bcd_adj;
  logic [4:0]  step;
  logic        sign_w, ovf_w;
  logic [15:0] num;

  logic [DIV_W-1:0] div, div_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      num_nxt;
  logic [3:0]       val_nxt;
  logic             blank_nxt;

  // 17-bit magnitude so that -32768 does not wrap before saturation
  always_comb begin
    value     = {data_inH, data_inL};
    abs_value = value[15] ? (17'h10000 - {1'b0, value}) : {1'b0, value};
    sat       = (abs_value > 17'd9999);
    mag_init  = sat ? 16'd9999 : abs_value[15:0];
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (step == 5'd16) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag    <= '0;
      bcd    <= '0;
      step   <= '0;
      sign_w <= 1'b0;
      ovf_w  <= 1'b0;
      num    <= '0;
      sign   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        mag    <= mag_init;
        sign_w <= value[15];
        ovf_w  <= sat;
        bcd    <= '0;
        step   <= '0;
      end else if (state == CONV && step != 5'd16) begin
        bcd  <= {bcd_adj[14:0], mag[15]};
        mag  <= {mag[14:0], 1'b0};
        step <= step + 5'd1;
      end
      if (commit) begin
        num  <= bcd;
        sign <= sign_w;
        ovf  <= ovf_w;
      end
    end
  end

  assign num_C3 = num[15:12];
  assign num_C2 = num[11:8];
  assign num_C1 = num[7:4];
  assign num_C0 = num[3:0];

  // Scan outputs are built from next-cycle index and committed value so a
  // commit landing on a scan advance never shows a stale digit.
  always_comb begin
    num_nxt = commit ? bcd : num;
    div_nxt = div + DIV_W'(1);
    idx_nxt = idx;
    if (div == DIV_W'(SCAN_DIV - 1)) begin
      div_nxt = '0;
      idx_nxt = idx + 2'd1;
    end
    val_nxt   = num_nxt[3:0];
    blank_nxt = 1'b0;
    case (idx_nxt)
      2'd0: begin
        val_nxt   = num_nxt[3:0];
        blank_nxt = 1'b0;
      end
      2'd1: begin
        val_nxt   = num_nxt[7:4];
        blank_nxt = (num_nxt[15:4] == 12'd0);
      end
      2'd2: begin
        val_nxt   = num_nxt[11:8];
        blank_nxt = (num_nxt[15:8] == 8'd0);
      end
      default: begin
        val_nxt   = num_nxt[15:12];
        blank_nxt = (num_nxt[15:12] == 4'd0);
      end
    endcase
    if (!BLANK_LZ) blank_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      idx         <= '0;
      digit_sel   <= 4'b1110;
      digit_val   <= '0;
      digit_blank <= 1'b0;
    end else begin
      div         <= div_nxt;
      idx         <= idx_nxt;
      digit_sel   <= ~(4'b0001 << idx_nxt);
      digit_val   <= val_nxt;
      digit_blank <= blank_nxt;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequential controller that owns the signed-16-bit to 4-digit BCD conversion and the multiplexed 7-segment display scan.
- Accepts a value as high/low bytes on a start strobe and runs a 16-step double-dabble conversion.
- Commits digits and sign atomically, then continuously time-multiplexes the committed digits onto one shared digit bus for the segment encoder.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is driven before the scan advances (≥2).
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 never blanked); 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- data_inH  in  8  high byte of two's-complement value.
- data_inL  in  8  low byte.
- busy  out  1  high from the edge that accepts start until return to IDLE.
- done  out  1  one-cycle pulse when results commit.
- num_C3  out  4  committed thousands digit.
- num_C2  out  4  committed hundreds digit.
- num_C1  out  4  committed tens digit.
- num_C0  out  4  committed units digit.
- sign  out  1  committed sign; 1 = negative.
- ovf  out  1  committed saturation flag.
- digit_sel  out  4  active-low one-hot digit enable; bit i selects num_Ci.
- digit_val  out  4  BCD value of the selected digit.
- digit_blank  out  1  selected digit is a blanked leading zero.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; busy=0, done=0.
  - num_C3..0 = 0, sign=0, ovf=0.
  - Scan index = 0, divider = 0, digit_sel = 4'b1110, digit_val = 0, digit_blank = 0.
  - Reset during CONV aborts the conversion; no done pulse; committed outputs = 0.
- FSM states: IDLE, CONV, DONE.
  - IDLE: on start=1 at edge E0, capture v = {data_inH, data_inL}.
    - If v[15]=1: mag = 0 - v (17-bit-safe); sign_n = 1. Otherwise mag = v; sign_n = 0.
    - If mag > 9999: mag = 9999 and ovf_n = 1. Otherwise ovf_n = 0.
    - Clear the BCD shift register and the step counter; go to CONV; busy=1.
  - CONV: one double-dabble step per cycle at edges E1..E16.
    - Each step adds 3 to every BCD nibble ≥5, then shifts left, taking mag's MSB in.
    - At edge E17 go to DONE.
  - DONE (entered at E17):
    - num_C3..0, sign and ovf load from the working registers in the same edge.
    - done=1 for exactly this cycle.
    - At E18 go to IDLE; busy=0.
- Latency: results visible and done high 17 edges after the accepting edge.
- Start throughput: start held high gives one conversion every 19 cycles. start in CONV or DONE is ignored, not queued.
- Inputs are sampled only at E0; later changes to data_inH/L do not affect the running conversion.
- Committed outputs hold their previous values for the whole conversion; the scanner never sees partial results.
- Negative zero cannot occur: sign_n = 0 whenever mag = 0.
- Scan:
  - Free-running divider 0..SCAN_DIV-1; scan index advances 0→1→2→3→0 when the divider wraps.
  - Scan runs independently of the FSM.
  - digit_sel = ~(1 << idx); digit_val = num_C[idx]; all are registered and update on the same edge as idx.
- Blanking, when BLANK_LZ=1, for idx > 0: digit_blank = 1 iff all num_C for positions ≥ idx are zero. When BLANK_LZ=0, digit_blank = 0.
- A commit that coincides with a scan advance: the scan outputs show the new index with the new committed value on the next cycle. No glitch, no stale mix.

Test Plan:
- {H,L}=0x04,0xD2 (1234), start 1 cycle → busy high 18 cycles; done at E17; C3..C0 = 1,2,3,4; sign=0; ovf=0.
- 0xFF,0x85 (−123) → C3..C0 = 0,1,2,3; sign=1; ovf=0. Then 0x00,0x00 → all 0, sign=0.
- 0x27,0x10 (10000) → 9,9,9,9 with ovf=1, sign=0. 0x80,0x00 (−32768) → 9,9,9,9 with ovf=1, sign=1.
- start held high with inputs changing every cycle → done every 19 cycles. Each result matches the inputs at its accept edge; start pulses during busy have no effect.
- SCAN_DIV=4, committed 0,0,4,2, BLANK_LZ=1:
  - digit_sel cycles 1110, 1101, 1011, 0111, each held 4 cycles.
  - digit_val = 2, 4, 0, 0.
  - digit_blank = 0, 0, 1, 1.
- rst_n low at E8 of a conversion → all outputs at reset values immediately (async), no done. After release, a new start converts normally.
